fft_out_reorder: RTL and testbench
==================================

// Module: fft_out_reorder
// PURPOSE
//  Output stage after the final butterfly stage (stage 5) of the 32-point radix-2 FFT.
//  - Captures one full frame of 32 complex results in a single cycle.
//  - The frame arrives in parallel, in bit-reversed order.
//  - Streams the frame out one complex bin per beat, in natural order (bin 0..31),
//    under a valid/ready handshake.
//  - This is the serial interface to downstream consumers (DMA, magnitude unit).
// PARAMETERS
//  DW     16  width of each real/imag component, two's complement
//  N      32  FFT points; fixed, set from package constant
//  LOG2N  5   index width; fixed, set from package constant
// PORTS
//  clk_MAC      in   1         single clock, rising edge
//  rst          in   1         asynchronous, active-low reset
//  frame_valid  in   1         frame_data holds a complete stage-5 frame
//  frame_ready  out  1         block can capture a frame this cycle
//  frame_data   in   N*2*DW    slot k at bits [k*2*DW +: 2*DW]; {im[DW-1:0], re[DW-1:0]}
//  out_valid    out  1         out_re/out_im/out_idx valid
//  out_ready    in   1         consumer accepts the beat
//  out_re       out  DW        real part of bin out_idx
//  out_im       out  DW        imag part of bin out_idx
//  out_idx      out  LOG2N     natural-order bin number
//  out_last     out  1         high with bin N-1
// BEHAVIOUR
//  Reset
//   - Async assert on rst low. FSM=IDLE; rd_cnt=0.
//   - out_valid=0, out_last=0, out_re=0, out_im=0, out_idx=0, frame_ready=1.
//   - Buffer contents are don't-care.
//  FSM: IDLE, STREAM.
//  Capture
//   - capture = frame_valid & frame_ready.
//   - Latches all N slots into buf[0..N-1] at the clock edge.
//   - Next state STREAM; rd_cnt=0.
//   - out_valid rises the cycle after capture (latency 1).
//  Read mapping
//   - Beat n outputs buf[bitrev5(n)] with out_idx=n.
//   - Example: beat 1 <- slot 16; beat 3 <- slot 24.
//  Handshake
//   - Beat accepted on out_valid & out_ready.
//   - Each acceptance increments rd_cnt.
//   - While out_valid=1 and out_ready=0: out_re, out_im, out_idx and out_last hold stable.
//   - out_valid never drops without acceptance.
//  frame_ready
//   - 1 in IDLE.
//   - In STREAM: 1 only when out_valid & out_ready & out_last (last beat being accepted).
//   - Combinational from out_ready.
//  Last beat
//   - Accepted without a capture -> IDLE, out_valid=0 next cycle.
//   - Accepted with a simultaneous capture -> new frame loaded, stay STREAM, rd_cnt=0.
//     Back-to-back frames have no bubble: bin 0 of the new frame appears the next cycle.
//  frame_valid while frame_ready=0
//   - Ignored, not queued.
//   - Upstream (stage-5 flag/count control) must hold frame_valid until frame_ready=1.
//  rd_cnt: LOG2N bits; wrap from N-1 to 0 only occurs via the last-beat rules above.
//  Reset mid-stream
//   - Frame discarded; outputs return to reset values immediately (async).
//  Arithmetic: pass-through without the option below; no width growth.
// CONFIGURATION
//  FFT_OUT_SCALE_EN
//   - Defined: out_re/out_im = (x + 2^(LOG2N-1)) >>> LOG2N.
//     - Arithmetic shift, round-half-up.
//     - Computed at DW+1 bits, result sign-extended back to DW; no overflow possible.
//     - Applies the 1/N normalisation.
//     - Rounding is registered on the read path; latency from capture to first beat stays 1 cycle.
//   - Undefined: raw stage-5 values, bit-exact.
// STRUCTURE
//  Package fft_pkg
//   - FFT_N=32, FFT_LOG2N=5, FFT_DW=16.
//   - typedef cplx_t {re, im}.
//   - function bitrev5(idx).
//   - State enum {IDLE, STREAM}.
//  Sub-module fft_round_shift
//   - DW in/out, SHIFT parameter.
//   - Instantiated twice (re, im) only under FFT_OUT_SCALE_EN.
//  Everything else stays in this module
//   - N x cplx_t register buffer.
//   - Read mux indexed by bitrev5(rd_cnt).
//   - FSM and counter.
// TESTING
//  1 Ramp frame
//    - Stimulus: slot k re=k, im=-k; out_ready=1.
//    - Response: 32 beats out_idx 0..31; beat n re=bitrev5(n), e.g. n=1 -> re=16, im=-16;
//      out_last only on beat 31.
//  2 Backpressure
//    - Stimulus: out_ready toggles 1,0,0,1 during beats 0-2.
//    - Response: data/idx stable while stalled; no beat lost or duplicated; 32 total.
//  3 Back-to-back frames
//    - Stimulus: frame B (re=100+k) presented during frame A's last beat.
//    - Response: frame_ready=1 that cycle; next cycle out_idx=0, re=100.
//  4 Blocked input
//    - Stimulus: frame_valid pulse mid-stream with frame_ready=0.
//    - Response: ignored; current frame completes unchanged; then IDLE.
//  5 Async reset
//    - Stimulus: rst low at beat 10.
//    - Response: out_valid=0 without waiting for a clock edge; after release frame_ready=1,
//      no beats emitted.
//  6 FFT_OUT_SCALE_EN
//    - Stimulus: slot values re=47, re=-48, re=32767.
//    - Response: re=1 (47+16=63, >>>5), re=-1 (-48+16=-32, >>>5), re=1024 respectively.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants, types and the index bit-reversal helper for the FFT output stage.
package fft_pkg;

   localparam int FFT_N     = 32;
   localparam int FFT_LOG2N = 5;
   localparam int FFT_DW    = 16;

   // Packing order matches one frame slot: {im, re}
   typedef struct packed {
      logic signed [FFT_DW-1:0] im;
      logic signed [FFT_DW-1:0] re;
   } cplx_t;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   function automatic logic [FFT_LOG2N-1:0] bitrev5(input logic [FFT_LOG2N-1:0] idx);
      logic [FFT_LOG2N-1:0] rev;
      for (int i = 0; i < FFT_LOG2N; i++) begin
         rev[i] = idx[FFT_LOG2N-1-i];
      end
      return rev;
   endfunction

endpackage

// File: rtl/fft_round_shift.sv
// Round-half-up arithmetic right shift by SHIFT, computed one bit wider so the
// rounding offset can never overflow; used for the 1/N output normalisation.
module fft_round_shift #(
   parameter int DW    = 16,
   parameter int SHIFT = 5
) (
   input  logic [DW-1:0] x,
   output logic [DW-1:0] y
);

   localparam logic signed [DW:0] HALF = (DW+1)'(1) << (SHIFT - 1);

   logic signed [DW:0] sum;

   assign sum = $signed({x[DW-1], x}) + HALF;
   assign y   = DW'(sum >>> SHIFT);

endmodule

// File: rtl/fft_out_reorder.sv
// Captures a bit-reversed 32-point FFT frame in one cycle and streams it out in natural
// order under valid/ready. Define FFT_OUT_SCALE_EN to apply rounded 1/N normalisation.
module fft_out_reorder
   import fft_pkg::*;
(
   input  logic                          clk_MAC,
   input  logic                          rst,
   input  logic                          frame_valid,
   output logic                          frame_ready,
   input  logic [FFT_N*2*FFT_DW-1:0]     frame_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [FFT_DW-1:0]             out_re,
   output logic [FFT_DW-1:0]             out_im,
   output logic [FFT_LOG2N-1:0]          out_idx,
   output logic                          out_last
);

   state_t                 state;
   logic [FFT_LOG2N-1:0]   rd_cnt;
   logic [FFT_LOG2N-1:0]   nxt_cnt;
   cplx_t                  frame_buf [FFT_N];
   cplx_t                  sel;
   logic [FFT_DW-1:0]      sel_re;
   logic [FFT_DW-1:0]      sel_im;
   logic                   capture;
   logic                   accept;

   assign accept      = out_valid & out_ready;
   assign frame_ready = (state == IDLE) | (accept & out_last);
   assign capture     = frame_valid & frame_ready;
   assign nxt_cnt     = rd_cnt + 5'd1;
   assign out_idx     = rd_cnt;

   // Bin 0 of a new frame comes straight from the input bus (bitrev5(0) = 0),
   // so the first beat appears one cycle after capture with no extra bubble.
   always_comb begin
      sel = frame_buf[bitrev5(nxt_cnt)];
      if (capture) begin
         sel = cplx_t'(frame_data[2*FFT_DW-1:0]);
      end
   end

`ifdef FFT_OUT_SCALE_EN
   fft_round_shift #(
      .DW    (FFT_DW),
      .SHIFT (FFT_LOG2N)
   ) u_round_re (
      .x (sel.re),
      .y (sel_re)
   );

   fft_round_shift #(
      .DW    (FFT_DW),
      .SHIFT (FFT_LOG2N)
   ) u_round_im (
      .x (sel.im),
      .y (sel_im)
   );
`else
   assign sel_re = sel.re;
   assign sel_im = sel.im;
`endif

   always_ff @(posedge clk_MAC) begin
      if (capture) begin
         for (int k = 0; k < FFT_N; k++) begin
            frame_buf[k] <= frame_data[k*2*FFT_DW +: 2*FFT_DW];
         end
      end
   end

   // rd_cnt always names the bin currently on the output registers.
   always_ff @(posedge clk_MAC or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         rd_cnt    <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
      end else if (capture) begin
         state     <= STREAM;
         rd_cnt    <= '0;
         out_valid <= 1'b1;
         out_last  <= 1'b0;
         out_re    <= sel_re;
         out_im    <= sel_im;
      end else if (state == STREAM && accept) begin
         if (out_last) begin
            state     <= IDLE;
            rd_cnt    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
         end else begin
            rd_cnt   <= nxt_cnt;
            out_last <= (nxt_cnt == FFT_LOG2N'(FFT_N - 1));
            out_re   <= sel_re;
            out_im   <= sel_im;
         end
      end
   end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Randomised and directed bench for fft_out_reorder, checked against a natural-order
// reference model of the frame. Honours FFT_OUT_SCALE_EN when defined.
module tb_fft_out_reorder;
   import fft_pkg::*;

   logic                       clk_MAC = 1'b0;
   logic                       rst;
   logic                       frame_valid;
   logic                       frame_ready;
   logic [FFT_N*2*FFT_DW-1:0]  frame_data;
   logic                       out_valid;
   logic                       out_ready;
   logic [FFT_DW-1:0]          out_re;
   logic [FFT_DW-1:0]          out_im;
   logic [FFT_LOG2N-1:0]       out_idx;
   logic                       out_last;

   int n_checks = 0;
   int n_fails  = 0;
   int mre [2][32];
   int mim [2][32];
   int cur = 0;

   localparam logic [3:0] STALL_PAT = 4'b1001;

   fft_out_reorder dut (
      .clk_MAC     (clk_MAC),
      .rst         (rst),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .frame_data  (frame_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_re      (out_re),
      .out_im      (out_im),
      .out_idx     (out_idx),
      .out_last    (out_last)
   );

   always #5 clk_MAC = ~clk_MAC;

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Natural bin n was produced in slot whose index is n read backwards in binary
   function automatic int rev(input int n);
      int r = 0;
      int v = n;
      repeat (5) begin
         r = r * 2 + v % 2;
         v = v / 2;
      end
      return r;
   endfunction

   // Expected output value: raw, or floor((x + 16) / 32) when normalising
   function automatic logic [15:0] expect_val(input int x);
      int s;
      int q;
      s = x;
      q = x;
`ifdef FFT_OUT_SCALE_EN
      s = x + 16;
      q = s / 32;
      if (s < 0 && (s % 32) != 0) q = q - 1;
`endif
      return 16'(q);
   endfunction

   task automatic make_frame(input int which, input int kind);
      logic signed [15:0] r;
      for (int k = 0; k < 32; k++) begin
         r = 16'($urandom);
         mre[which][k] = r;
         r = 16'($urandom);
         mim[which][k] = r;
         if (kind == 0) begin
            mre[which][k] = k;
            mim[which][k] = -k;
         end else if (kind == 2) begin
            mre[which][k] = 100 + k;
         end
      end
      if (kind == 3) begin
         mre[which][0]  = 47;
         mre[which][16] = -48;
         mre[which][8]  = 32767;
      end
   endtask

   function automatic logic [FFT_N*2*FFT_DW-1:0] pack(input int which);
      logic [FFT_N*2*FFT_DW-1:0] v;
      v = '0;
      for (int k = 0; k < 32; k++) begin
         v[k*32 +: 16]      = 16'(mre[which][k]);
         v[k*32 + 16 +: 16] = 16'(mim[which][k]);
      end
      return v;
   endfunction

   // Called at a negedge with the DUT idle; returns at the negedge after capture
   task automatic apply_stimulus(input string tag, input int which);
      frame_data  = pack(which);
      frame_valid = 1'b1;
      out_ready   = 1'b0;
      #1;
      check_output({tag, "_frame_ready"}, frame_ready, 1);
      @(negedge clk_MAC);
      frame_valid = 1'b0;
      #1;
      check_output({tag, "_latency_valid"}, out_valid, 1);
      check_output({tag, "_first_idx"}, out_idx, 0);
   endtask

   // mode 0: always ready, 1: 1,0,0,1 then random, 2: random
   task automatic receive_beats(input string tag, input int first, input int stop, input int mode);
      int n = first;
      int steps = 0;
      while (n < stop && steps < 500) begin
         if (mode == 0) out_ready = 1'b1;
         else if (mode == 1 && steps < 4) out_ready = STALL_PAT[steps];
         else out_ready = 1'($urandom_range(0, 1));
         #1;
         if (mode == 0) check_output($sformatf("%s_valid_%0d", tag, n), out_valid, 1);
         if (out_valid) begin
            check_output($sformatf("%s_idx_%0d", tag, n), out_idx, n);
            check_output($sformatf("%s_re_%0d", tag, n), out_re, expect_val(mre[cur][rev(n)]));
            check_output($sformatf("%s_im_%0d", tag, n), out_im, expect_val(mim[cur][rev(n)]));
            check_output($sformatf("%s_last_%0d", tag, n), out_last, (n == 31));
            if (out_ready) n++;
         end
         steps++;
         @(negedge clk_MAC);
      end
      check_output({tag, "_beat_count"}, n, stop);
   endtask

   task automatic check_idle(input string tag);
      out_ready = 1'b0;
      #1;
      check_output({tag, "_idle_valid"}, out_valid, 0);
      check_output({tag, "_idle_ready"}, frame_ready, 1);
   endtask

   initial begin
      rst         = 1'b0;
      frame_valid = 1'b0;
      out_ready   = 1'b0;
      frame_data  = '0;
      repeat (3) @(negedge clk_MAC);
      #1;
      check_output("reset_valid", out_valid, 0);
      check_output("reset_last", out_last, 0);
      check_output("reset_re", out_re, 0);
      check_output("reset_im", out_im, 0);
      check_output("reset_idx", out_idx, 0);
      check_output("reset_frame_ready", frame_ready, 1);
      @(negedge clk_MAC);
      rst = 1'b1;
      @(negedge clk_MAC);

      $display("[TB] ramp frame");
      cur = 0;
      make_frame(0, 0);
      apply_stimulus("ramp", 0);
      receive_beats("ramp", 0, 32, 0);
      check_idle("ramp");
      @(negedge clk_MAC);

      $display("[TB] backpressure on random frame");
      make_frame(0, 1);
      apply_stimulus("bp", 0);
      receive_beats("bp", 0, 32, 1);
      check_idle("bp");
      @(negedge clk_MAC);

      $display("[TB] back-to-back frames");
      make_frame(0, 1);
      make_frame(1, 2);
      apply_stimulus("b2b_a", 0);
      receive_beats("b2b_a", 0, 31, 2);
      frame_data  = pack(1);
      frame_valid = 1'b1;
      out_ready   = 1'b1;
      #1;
      check_output("b2b_frame_ready", frame_ready, 1);
      check_output("b2b_a_last", out_last, 1);
      check_output("b2b_a_idx31", out_idx, 31);
      check_output("b2b_a_re31", out_re, expect_val(mre[0][31]));
      @(negedge clk_MAC);
      frame_valid = 1'b0;
      cur = 1;
      receive_beats("b2b_b", 0, 32, 0);
      check_idle("b2b");
      @(negedge clk_MAC);

      $display("[TB] blocked frame_valid mid-stream");
      cur = 0;
      make_frame(0, 1);
      make_frame(1, 1);
      apply_stimulus("blk", 0);
      receive_beats("blk", 0, 10, 0);
      frame_data  = pack(1);
      frame_valid = 1'b1;
      out_ready   = 1'b0;
      #1;
      check_output("blk_frame_ready", frame_ready, 0);
      @(negedge clk_MAC);
      frame_valid = 1'b0;
      receive_beats("blk", 10, 32, 2);
      check_idle("blk");
      @(negedge clk_MAC);

      $display("[TB] async reset mid-stream");
      make_frame(0, 1);
      apply_stimulus("rst", 0);
      receive_beats("rst", 0, 10, 0);
      out_ready = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      check_output("arst_valid", out_valid, 0);
      check_output("arst_idx", out_idx, 0);
      check_output("arst_re", out_re, 0);
      check_output("arst_last", out_last, 0);
      check_output("arst_frame_ready", frame_ready, 1);
      repeat (2) @(negedge clk_MAC);
      rst = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk_MAC);
         #1;
         check_output($sformatf("arst_no_beat_%0d", c), out_valid, 0);
      end
      @(negedge clk_MAC);

`ifdef FFT_OUT_SCALE_EN
      $display("[TB] normalisation directed values");
      make_frame(0, 3);
      apply_stimulus("scale", 0);
      out_ready = 1'b1;
      #1;
      check_output("scale_47", out_re, 16'd1);
      @(negedge clk_MAC);
      #1;
      check_output("scale_m48", out_re, 16'hFFFF);
      @(negedge clk_MAC);
      #1;
      check_output("scale_32767", out_re, 16'd1024);
      out_ready = 1'b0;
      @(negedge clk_MAC);
      receive_beats("scale", 3, 32, 2);
      check_idle("scale");
      @(negedge clk_MAC);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
